// File: rtl/fifo_prog_pkg.sv
// Shared constants and helpers for the programmable-threshold FIFO.
// Build option: define FIFO_PROG_FWFT_EN for first-word-fall-through read data.
package fifo_prog_pkg;

  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_prog_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with runtime-programmable almost-full/almost-empty thresholds.
// Build option: define FIFO_PROG_FWFT_EN for first-word-fall-through read data.
module fifo_prog
  import fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int CNT_W = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FIFO_WIDTH-1:0] mem_rdata;
  logic                  wr_accept;
  logic                  rd_accept;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);

  // Gating on full/empty makes the full+both and empty+both cases fall out naturally.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  fifo_prog_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_accept;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_PROG_FWFT_EN
  assign data_out = mem_rdata;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_accept) begin
      data_out <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog (WIDTH=16, DEPTH=8); FWFT checks are
// enabled when FIFO_PROG_FWFT_EN is defined.
module tb_fifo_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  af_thresh;
  logic [3:0]  ae_thresh;
  logic [15:0] data_out;
  logic        wr_ack;
  logic        overflow;
  logic        underflow;
  logic        full;
  logic        empty;
  logic        almostfull;
  logic        almostempty;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic ack;
    logic ovf;
    logic udf;
  } hs_t;

  hs_t         hs_q[$];
  logic [15:0] data_q[$];
  hs_t         hs_cur;
  logic        hs_cur_vld = 1'b0;
  logic        rd_pend = 1'b0;

  fifo_prog #(
    .FIFO_WIDTH (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .af_thresh   (af_thresh),
    .ae_thresh   (ae_thresh),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake pulses are compared the negedge after their edge; read
  // data is compared whenever the DUT accepts a read.
  always @(negedge clk) begin
    if (hs_cur_vld) begin
      chk("wr_ack", 32'(wr_ack), 32'(hs_cur.ack));
      chk("overflow", 32'(overflow), 32'(hs_cur.ovf));
      chk("underflow", 32'(underflow), 32'(hs_cur.udf));
    end
    if (hs_q.size() > 0) begin
      hs_cur     = hs_q.pop_front();
      hs_cur_vld = 1'b1;
    end else begin
      hs_cur_vld = 1'b0;
    end
`ifdef FIFO_PROG_FWFT_EN
    if (rd_en && !empty) begin
      if (data_q.size() == 0) chk("unexpected_read", 32'(data_out), 32'hFFFF_FFFF);
      else chk("data_out", 32'(data_out), 32'(data_q.pop_front()));
    end
`else
    if (rd_pend) begin
      if (data_q.size() == 0) chk("unexpected_read", 32'(data_out), 32'hFFFF_FFFF);
      else chk("data_out", 32'(data_out), 32'(data_q.pop_front()));
    end
    rd_pend = rd_en && !empty;
`endif
  end

  // Drives one cycle of stimulus and records what the DUT should answer.
  task automatic step(input logic wr, input logic rd, input logic [15:0] din,
                      input logic ack, input logic ovf, input logic udf,
                      input logic rd_ok, input logic [15:0] rdata);
    hs_t h;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    h.ack = ack;
    h.ovf = ovf;
    h.udf = udf;
    hs_q.push_back(h);
    if (rd_ok) data_q.push_back(rdata);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    step(1'b1, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic rd(input logic [15:0] d);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] c, input logic f, input logic e);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_full"}, 32'(full), 32'(f));
    chk({tag, "_empty"}, 32'(empty), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic af_tbl [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic ae_tbl [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    data_in   = '0;
    af_thresh = 4'd6;
    ae_thresh = 4'd2;
    #12;
    chk_state("reset", 4'd0, 1'b0, 1'b1);
    chk("reset_wr_ack", 32'(wr_ack), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_underflow", 32'(underflow), 32'd0);
`ifndef FIFO_PROG_FWFT_EN
    chk("reset_data_out", 32'(data_out), 32'd0);
`endif
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, then overflow
    for (int i = 1; i <= 8; i++) wr(16'(i));
    chk_state("fill", 4'd8, 1'b1, 1'b0);
    chk("fill_almostfull", 32'(almostfull), 32'd1);
    step(1'b1, 1'b0, 16'h0009, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk_state("overfill", 4'd8, 1'b1, 1'b0);

    // Drain, then underflow
    for (int i = 1; i <= 8; i++) rd(16'(i));
    chk_state("drain", 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(1);
`ifndef FIFO_PROG_FWFT_EN
    chk("underflow_hold_data", 32'(data_out), 32'h0008);
`endif
    chk_state("underrun", 4'd0, 1'b0, 1'b1);

    // Thresholds
    for (int i = 0; i < 6; i++) begin
      wr(16'hB000 + 16'(i));
      chk($sformatf("af_at_%0d", i + 1), 32'(almostfull), 32'(af_tbl[i]));
      chk($sformatf("ae_at_%0d", i + 1), 32'(almostempty), 32'(ae_tbl[i]));
    end
    af_thresh = 4'd7;
    #1;
    chk("af_thresh_change", 32'(almostfull), 32'd0);
    af_thresh = 4'd6;
    for (int i = 0; i < 6; i++) rd(16'hB000 + 16'(i));
    chk_state("thresh_drain", 4'd0, 1'b0, 1'b1);

    // Wrap-around
    for (int i = 0; i < 5; i++) wr(16'hC000 + 16'(i));
    for (int i = 0; i < 5; i++) rd(16'hC000 + 16'(i));
    for (int i = 0; i < 6; i++) wr(16'hA000 + 16'(i));
    chk_state("wrap_mid", 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) rd(16'hA000 + 16'(i));
    chk_state("wrap_end", 4'd0, 1'b0, 1'b1);

    // Simultaneous read/write while full, then while empty
    for (int i = 0; i < 8; i++) wr(16'hD000 + 16'(i));
    step(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b1, 16'hD000);
    chk_state("full_both", 4'd7, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) rd(16'hD000 + 16'(i));
    step(1'b1, 1'b1, 16'hE000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    chk_state("empty_both", 4'd1, 1'b0, 1'b0);
    rd(16'hE000);
    chk_state("empty_both_drain", 4'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) wr(16'h4000 + 16'(i));
    chk_state("pre_reset", 4'd4, 1'b0, 1'b0);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk_state("async_reset", 4'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wr(16'hF00F);
    rd(16'hF00F);
    chk_state("post_reset", 4'd0, 1'b0, 1'b1);

`ifdef FIFO_PROG_FWFT_EN
    wr(16'h1234);
    chk("fwft_not_empty", 32'(empty), 32'd0);
    chk("fwft_head", 32'(data_out), 32'h1234);
    wr(16'h5678);
    rd(16'h1234);
    chk("fwft_next_head", 32'(data_out), 32'h5678);
    rd(16'h5678);
    chk_state("fwft_end", 4'd0, 1'b0, 1'b1);
`endif

    idle(2);
    chk("data_q_drained", 32'(data_q.size()), 32'd0);
    chk("hs_q_drained", 32'(hs_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
